// File: rtl/soc_system_pio_pkg.sv
// Shared constants and bus payload type for the SoC PIO slaves.
package soc_system_pio_pkg;

    localparam int unsigned AVL_ADDR_W = 2;
    localparam int unsigned AVL_DATA_W = 32;

    // Register word offsets
    localparam logic [AVL_ADDR_W-1:0] REG_DATA    = 2'd0;
    localparam logic [AVL_ADDR_W-1:0] REG_RSVD    = 2'd1;
    localparam logic [AVL_ADDR_W-1:0] REG_IRQMASK = 2'd2;
    localparam logic [AVL_ADDR_W-1:0] REG_EDGECAP = 2'd3;

    // Captured edge selection
    localparam int unsigned EDGE_FALL = 0;
    localparam int unsigned EDGE_RISE = 1;
    localparam int unsigned EDGE_ANY  = 2;

    // Avalon-MM slave write-side request
    typedef struct packed {
        logic [AVL_ADDR_W-1:0] address;
        logic                  chipselect;
        logic                  write_n;
        logic [AVL_DATA_W-1:0] writedata;
    } avl_req_t;

endpackage

// File: rtl/soc_system_button_debounce_bit.sv
// One button bit: two-flop synchroniser followed by a stable-count debouncer.
module soc_system_button_debounce_bit
    import soc_system_pio_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned IDLE_LEVEL      = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pin,
    output logic o_debounced
);

    localparam int unsigned      CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic             IDLE_BIT = 1'(IDLE_LEVEL);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_deb;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nx;
    logic             w_deb_nx;

    // Bring the asynchronous pin into the clk domain
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= IDLE_BIT;
            r_sync2 <= IDLE_BIT;
        end else begin
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles in a row
    always_comb begin
        w_cnt_nx = r_cnt;
        w_deb_nx = r_deb;
        if (r_sync2 == r_deb) begin
            w_cnt_nx = '0;
        end else if (r_cnt == CNT_LAST) begin
            w_deb_nx = r_sync2;
            w_cnt_nx = '0;
        end else begin
            w_cnt_nx = r_cnt + CNT_W'(1);
        end
    end

    // Debounce state registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_deb <= IDLE_BIT;
        end else begin
            r_cnt <= w_cnt_nx;
            r_deb <= w_deb_nx;
        end
    end

    assign o_debounced = r_deb;

endmodule

// File: rtl/soc_system_button_debounce_pio.sv
// Push-button input PIO: debounced data, edge capture with W1C and masked level irq.
module soc_system_button_debounce_pio
    import soc_system_pio_pkg::*;
#(
    parameter int unsigned WIDTH           = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned EDGE_TYPE       = 0,
    parameter int unsigned IDLE_LEVEL      = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [AVL_ADDR_W-1:0] address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [AVL_DATA_W-1:0] writedata,
    input  logic [WIDTH-1:0]      in_port,
    output logic [AVL_DATA_W-1:0] readdata,
    output logic                  irq
);

    localparam logic IDLE_BIT = 1'(IDLE_LEVEL);

    avl_req_t         w_req;
    logic             w_wr_en;
    logic [WIDTH-1:0] w_wdata;
    logic             w_unused;
    logic [WIDTH-1:0] w_deb;
    logic [WIDTH-1:0] w_event;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_mask_nx;
    logic [WIDTH-1:0] w_ecap_nx;
    logic [WIDTH-1:0] r_deb_d;
    logic [WIDTH-1:0] r_irq_mask;
    logic [WIDTH-1:0] r_edge_cap;

    assign w_req    = '{address: address, chipselect: chipselect,
                        write_n: write_n, writedata: writedata};
    assign w_wr_en  = w_req.chipselect & ~w_req.write_n;
    assign w_wdata  = w_req.writedata[WIDTH-1:0];
    assign w_unused = &{1'b0, w_req.writedata};

    // Per-bit synchroniser and debouncer
    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        soc_system_button_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .IDLE_LEVEL      (IDLE_LEVEL)
        ) u_bit (
            .i_clk       (clk),
            .i_rst_n     (reset_n),
            .i_pin       (in_port[g]),
            .o_debounced (w_deb[g])
        );
    end

    // Delayed copy of debounced; resets to the idle level so reset release is edge-free
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_deb_d <= {WIDTH{IDLE_BIT}};
        end else begin
            r_deb_d <= w_deb;
        end
    end

    // Select which debounced transitions count as events
    always_comb begin
        w_event = '0;
        if (EDGE_TYPE == EDGE_RISE) begin
            w_event = w_deb & ~r_deb_d;
        end else if (EDGE_TYPE == EDGE_ANY) begin
            w_event = w_deb ^ r_deb_d;
        end else begin
            w_event = ~w_deb & r_deb_d;
        end
    end

    // Register write decode; a new event overrides a same-cycle clear
    always_comb begin
        w_mask_nx = r_irq_mask;
        w_clr     = '0;
        if (w_wr_en && (w_req.address == REG_IRQMASK)) begin
            w_mask_nx = w_wdata;
        end
        if (w_wr_en && (w_req.address == REG_EDGECAP)) begin
            w_clr = w_wdata;
        end
        w_ecap_nx = (r_edge_cap & ~w_clr) | w_event;
    end

    // Control/status registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_mask <= '0;
            r_edge_cap <= '0;
        end else begin
            r_irq_mask <= w_mask_nx;
            r_edge_cap <= w_ecap_nx;
        end
    end

    // Zero-wait-state read mux
    always_comb begin
        readdata = '0;
        case (address)
            REG_DATA:    readdata = AVL_DATA_W'(w_deb);
            REG_RSVD:    readdata = '0;
            REG_IRQMASK: readdata = AVL_DATA_W'(r_irq_mask);
            REG_EDGECAP: readdata = AVL_DATA_W'(r_edge_cap);
            default:     readdata = '0;
        endcase
    end

    // Level interrupt from captured and enabled bits
    assign irq = |(r_edge_cap & r_irq_mask);

endmodule

// File: tb/tb_soc_system_button_debounce_pio.sv
// Bench for the debounced button PIO: directed scenarios plus randomized traffic vs a reference model.
module tb_soc_system_button_debounce_pio;
    import soc_system_pio_pkg::*;

    localparam int unsigned W  = 3;
    localparam int unsigned D  = 8;
    localparam int unsigned ET = 0;
    localparam int unsigned IL = 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [1:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [W-1:0]  in_port;
    logic [31:0]   readdata;
    logic          irq;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    soc_system_button_debounce_pio #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (D),
        .EDGE_TYPE       (ET),
        .IDLE_LEVEL      (IL)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    // Reference model: pin is seen two edges late; a bit flips once its last D
    // synchronised samples all disagree with the accepted level.
    logic [W-1:0] m_s1, m_s2, m_deb, m_prev, m_mask, m_ec;
    logic [D-1:0] m_hist    [W];
    logic [D-1:0] m_hist_nx [W];
    logic [W-1:0] m_deb_nx, m_ev, m_clr;
    logic         m_wr;

    always_comb begin
        m_wr  = chipselect && !write_n;
        m_clr = (m_wr && address == REG_EDGECAP) ? writedata[W-1:0] : '0;
        for (int i = 0; i < int'(W); i++) begin
            m_hist_nx[i] = {m_hist[i][D-2:0], m_s2[i]};
            m_deb_nx[i]  = (m_hist_nx[i] == {D{~m_deb[i]}}) ? ~m_deb[i] : m_deb[i];
        end
        case (ET)
            0:       m_ev = m_prev & ~m_deb;
            1:       m_ev = ~m_prev & m_deb;
            default: m_ev = m_prev ^ m_deb;
        endcase
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_s1   <= {W{1'(IL)}};
            m_s2   <= {W{1'(IL)}};
            m_deb  <= {W{1'(IL)}};
            m_prev <= {W{1'(IL)}};
            m_mask <= '0;
            m_ec   <= '0;
            for (int i = 0; i < int'(W); i++) m_hist[i] <= {D{1'(IL)}};
        end else begin
            m_s1   <= in_port;
            m_s2   <= m_s1;
            m_hist <= m_hist_nx;
            m_deb  <= m_deb_nx;
            m_prev <= m_deb;
            if (m_wr && address == REG_IRQMASK) m_mask <= writedata[W-1:0];
            m_ec   <= (m_ec & ~m_clr) | m_ev;
        end
    end

    function automatic logic [31:0] exp_read(input logic [1:0] a);
        case (a)
            2'd0:    return 32'(m_deb);
            2'd2:    return 32'(m_mask);
            2'd3:    return 32'(m_ec);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic exp_irq();
        return |(m_ec & m_mask);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock and compare the visible outputs with the model
    task automatic cyc();
        @(posedge clk);
        #1;
        check("model_rd", readdata, exp_read(address));
        check("model_irq", 32'(irq), 32'(exp_irq()));
    endtask

    // Read a register combinationally and compare with a fixed value
    task automatic peek(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [1:0] saved;
        saved   = address;
        address = a;
        #1;
        check(tag, readdata, exp);
        address = saved;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        cyc();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        address    = 2'd0;
    endtask

    initial begin
        int hold [W];
        reset_n    = 1'b0;
        in_port    = 3'b111;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        peek("rst_data", 2'd0, 32'h7);
        peek("rst_rsvd", 2'd1, 32'h0);
        peek("rst_mask", 2'd2, 32'h0);
        peek("rst_ecap", 2'd3, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        reset_n = 1'b1;
        repeat (3) cyc();

        // Press bit0: exact acceptance and capture timing, masked irq
        in_port[0] = 1'b0;
        repeat (9) cyc();
        peek("press_data_early", 2'd0, 32'h7);
        cyc();
        peek("press_data", 2'd0, 32'h6);
        peek("press_ecap_early", 2'd3, 32'h0);
        cyc();
        peek("press_ecap", 2'd3, 32'h1);
        check("press_irq_masked", 32'(irq), 32'h0);

        // Enabled irq follows capture and drops after W1C
        wr(2'd3, 32'h1);
        peek("w1c_ecap", 2'd3, 32'h0);
        in_port[0] = 1'b1;
        repeat (12) cyc();
        peek("release_ecap", 2'd3, 32'h0);
        wr(2'd2, 32'h1);
        peek("mask_rd", 2'd2, 32'h1);
        in_port[0] = 1'b0;
        repeat (10) cyc();
        check("irq_before", 32'(irq), 32'h0);
        cyc();
        check("irq_rise", 32'(irq), 32'h1);
        peek("irq_ecap", 2'd3, 32'h1);
        wr(2'd3, 32'h1);
        check("irq_cleared", 32'(irq), 32'h0);
        peek("irq_ecap_clr", 2'd3, 32'h0);
        in_port[0] = 1'b1;
        repeat (12) cyc();

        // Glitches one cycle shorter than the debounce window never land
        repeat (3) begin
            in_port[1] = 1'b0;
            repeat (7) begin
                cyc();
                peek("glitch_data", 2'd0, 32'h7);
            end
            in_port[1] = 1'b1;
            cyc();
            peek("glitch_data", 2'd0, 32'h7);
        end
        repeat (12) cyc();
        peek("glitch_data_end", 2'd0, 32'h7);
        peek("glitch_ecap", 2'd3, 32'h0);

        // Clear collides with a new capture on the same bit: set wins
        in_port[1] = 1'b0;
        repeat (10) cyc();
        wr(2'd3, 32'h2);
        peek("set_wins", 2'd3, 32'h2);
        wr(2'd3, 32'h2);
        peek("set_wins_clr", 2'd3, 32'h0);
        in_port[1] = 1'b1;
        repeat (12) cyc();

        // Reset in the middle of a bit2 press, released with the pin still low
        in_port[2] = 1'b0;
        repeat (7) cyc();
        reset_n = 1'b0;
        #1;
        peek("midrst_data", 2'd0, 32'h7);
        peek("midrst_mask", 2'd2, 32'h0);
        repeat (2) cyc();
        reset_n = 1'b1;
        cyc();
        peek("midrst_no_edge", 2'd3, 32'h0);
        repeat (8) cyc();
        peek("midrst_data_early", 2'd0, 32'h7);
        cyc();
        peek("midrst_data", 2'd0, 32'h3);
        peek("midrst_ecap_early", 2'd3, 32'h0);
        cyc();
        peek("midrst_ecap", 2'd3, 32'h4);

        // Randomized pins and bus traffic against the model
        for (int i = 0; i < int'(W); i++) hold[i] = 1;
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < int'(W); i++) begin
                hold[i]--;
                if (hold[i] <= 0) begin
                    in_port[i] = 1'($urandom_range(0, 1));
                    hold[i]    = int'($urandom_range(1, 14));
                end
            end
            address    = 2'($urandom_range(0, 3));
            writedata  = $urandom;
            chipselect = 1'($urandom_range(0, 1));
            write_n    = ($urandom_range(0, 5) != 0);
            reset_n    = !(n >= 1000 && n < 1003);
            cyc();
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
        reset_n    = 1'b1;
        repeat (2) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
